// File: rtl/lifo_fifo_pkg.sv
// Shared definitions for the LIFO/FIFO buffer: mode encodings and config check.
package lifo_fifo_pkg;

  localparam logic MODE_FIFO = 1'b0;
  localparam logic MODE_LIFO = 1'b1;

  // Width must be non-zero; depth must be a power of two of at least 2.
  function automatic bit cfg_legal(input int width, input int depth);
    return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/lifo_fifo_buffer_if.sv
// Control, data and status bundle of the LIFO/FIFO buffer.
interface lifo_fifo_buffer_if #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              mode;
  logic              clear;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              mode_active;
  logic              overflow;
  logic              underflow;

  modport master (
    output mode, clear, push, pop, din,
    input  dout, dout_valid, full, empty, count, mode_active, overflow, underflow
  );

  modport slave (
    input  mode, clear, push, pop, din,
    output dout, dout_valid, full, empty, count, mode_active, overflow, underflow
  );
endinterface

// File: rtl/lifo_fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one combinational read port.
module lifo_fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/lifo_fifo_buffer.sv
// Run-time selectable LIFO/FIFO buffer with status, sticky errors and flush.
module lifo_fifo_buffer
  import lifo_fifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  lifo_fifo_buffer_if.slave bus
);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  if (!cfg_legal(WIDTH, DEPTH)) begin : g_bad_cfg
    $error("lifo_fifo_buffer: illegal WIDTH/DEPTH");
  end

  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] sp, sp_m1;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [WIDTH-1:0]  rdata;
  logic [WIDTH-1:0]  dout_q;
  logic              dout_vld_q;
  logic              mode_q;
  logic              ovf_q, udf_q;
  logic              full, empty;
  logic              push_ok, pop_ok;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign pop_ok  = bus.pop & ~empty;
  assign push_ok = bus.push & (~full | pop_ok);

  // Stack pointer view of count; sp is only used as a write address when not full.
  assign sp    = cnt[ADDR_W-1:0];
  assign sp_m1 = sp - PTR_ONE;

  // Address selection. An empty buffer always restarts at slot 0, so a mode
  // switch (only possible while empty) never leaves stale pointer offsets.
  always_comb begin
    raddr = (mode_q == MODE_LIFO) ? sp_m1 : rd_ptr;
    waddr = wr_ptr;
    if (empty)                     waddr = '0;
    else if (mode_q == MODE_LIFO)  waddr = pop_ok ? sp_m1 : sp;
  end

  lifo_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (push_ok & ~reset & ~bus.clear),
    .waddr (waddr),
    .wdata (bus.din),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Pointers, count, read data, sticky flags and mode latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      mode_q     <= bus.mode;
    end else if (bus.clear) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      mode_q     <= bus.mode;
    end else begin
      if (empty) mode_q <= bus.mode;
      if (bus.push & ~push_ok) ovf_q <= 1'b1;
      if (bus.pop  & ~pop_ok)  udf_q <= 1'b1;

      dout_vld_q <= pop_ok;
      if (pop_ok) dout_q <= rdata;

      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase

      if (empty) begin
        wr_ptr <= push_ok ? PTR_ONE : '0;
        rd_ptr <= '0;
      end else if (mode_q == MODE_FIFO) begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_vld_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = cnt;
  assign bus.mode_active = mode_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
endmodule

// File: doc/lifo_fifo_buffer.md
Name: lifo_fifo_buffer

Overview:
Parametrised single-clock buffer that can run as a LIFO stack or as a FIFO queue, selected at run time. It is the next generation of the team's byte stack. Push and pop each complete in one cycle, with no two-step sequencing. It adds configurable width and depth, full/empty/count status, sticky overflow/underflow errors and a synchronous flush. It sits between the pad-level input bus and the output bus of a tile, or is used standalone as a scratch buffer.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; must be a power of two, >=2
ADDR_W, $clog2(DEPTH), derived pointer width; not to be overridden

Ports:
clk  input  1  single clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
mode  input  1  requested mode: 0 = FIFO, 1 = LIFO
clear  input  1  synchronous flush of contents and error flags
push  input  1  write request for din
pop  input  1  read request
din  input  WIDTH  write data
dout  output  WIDTH  registered read data
dout_valid  output  1  one-cycle pulse: dout was updated by an accepted pop
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  ADDR_W+1  current number of stored entries
mode_active  output  1  mode currently in force
overflow  output  1  sticky: a push was rejected
underflow  output  1  sticky: a pop was rejected

Behaviour:
- Reset (priority over everything):
  - Clears all pointers and count.
  - dout=0, dout_valid=0, overflow=0, underflow=0.
  - mode_active takes the value of mode.
  - Memory contents are not cleared.
- clear (priority over push/pop, below reset):
  - Clears pointers, count, overflow and underflow.
  - dout_valid=0; dout holds its value.
  - mode_active takes the value of mode.
- Mode latch:
  - mode_active <= mode only on cycles where empty=1 at the clock edge, or on reset or clear.
  - Otherwise mode changes are ignored until the buffer drains.
- Acceptance, evaluated on pre-edge state:
  - push_ok = push & (!full | pop_ok)
  - pop_ok = pop & !empty
  - A rejected push sets overflow; a rejected pop sets underflow.
  - Both flags stay sticky until reset or clear.
- FIFO operation:
  - Uses wr_ptr and rd_ptr, each ADDR_W bits, wrapping modulo DEPTH.
  - push_ok: mem[wr_ptr] <= din; wr_ptr++.
  - pop_ok: dout <= mem[rd_ptr]; rd_ptr++.
- LIFO operation:
  - Uses sp = count; the top of stack is mem[sp-1].
  - push_ok only: mem[sp] <= din; count++.
  - pop_ok only: dout <= mem[sp-1]; count--.
  - push_ok and pop_ok together (non-empty): dout <= old top; mem[sp-1] <= din; count unchanged (top replaced).
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never wraps below 0.
- Simultaneous push and pop:
  - Empty: only the push is accepted (no pass-through); underflow is set.
  - Full: both are accepted; full stays 1.
- Latency and status timing:
  - dout and dout_valid are registered and appear one cycle after the accepted pop.
  - dout holds its last value when there is no pop.
  - full, empty and count reflect post-edge state, combinationally derived from registered count.
- Reset or clear asserted mid-stream discards all contents; there is no partial completion.

Decomposition:
- Shared package lifo_fifo_pkg:
  - MODE_FIFO=1'b0 and MODE_LIFO=1'b1 constants or enum.
  - A width/depth legality check function.
- One sub-module, lifo_fifo_ram:
  - DEPTH x WIDTH storage with one synchronous write port and one combinational read port.
  - No reset.
- Pointer, count and flag logic stays in lifo_fifo_buffer.

Test Plan:
1. FIFO order (WIDTH=8, DEPTH=4, mode=0): push 0x11, 0x22, 0x33, then pop 3 times -> dout 0x11, 0x22, 0x33, each one cycle after its pop with dout_valid=1; empty=1 at the end.
2. LIFO order (mode=1): push 0xA1, 0xB2, 0xC3, then pop 3 times -> dout 0xC3, 0xB2, 0xA1; count steps 3, 2, 1, 0.
3. Full/overflow: push 5 words into DEPTH=4 -> full=1 after the 4th, 5th push rejected, overflow=1, count=4; popping all 4 returns only the first four words in mode order.
4. Underflow and empty push+pop: pop on empty -> dout unchanged, dout_valid=0, underflow=1. push 0x5A with pop on empty -> count=1, underflow stays 1. clear -> both flags 0, count=0.
5. Simultaneous at full:
   - FIFO full of 1, 2, 3, 4, push 0x09 with pop -> dout=1, count=4; draining then yields 2, 3, 4, 9.
   - LIFO full, push 0x77 with pop -> dout=old top, next pop returns 0x77.
6. Mode latch and reset: FIFO holding 2 entries, set mode=1 -> mode_active stays 0 until the buffer drains, then becomes 1. Assert reset mid-stream -> count=0, dout=0, flags 0 on the next cycle.
